// File: rtl/arcade_input_cond.sv
// Per-channel button conditioner: 2-flop sync, tick debounce, coin pulse / autofire, pause freeze.
// Optional sticky rise flags enabled by defining INPUT_COND_STICKY_EN.
module arcade_input_cond #(
  parameter int unsigned CHANNELS = 16,
  parameter int unsigned CNT_W    = 8
) (
  input  logic                clk_sys,
  input  logic                reset,
  input  logic                tick,
  input  logic [CHANNELS-1:0] raw,
  input  logic [CHANNELS-1:0] mode_pulse,
  input  logic [CHANNELS-1:0] mode_auto,
  input  logic [CNT_W-1:0]    db_len,
  input  logic [CNT_W-1:0]    pulse_len,
  input  logic [CNT_W-1:0]    auto_half,
  input  logic                freeze,
  input  logic                sticky_clr,
  output logic [CHANNELS-1:0] out_n,
  output logic [CHANNELS-1:0] rise,
  output logic [CHANNELS-1:0] sticky
);

  logic [CHANNELS-1:0] s1_q, s2_q;
  logic [CHANNELS-1:0] stable_q, stable_d;
  logic [CHANNELS-1:0] prev_q, prev_d;
  logic [CHANNELS-1:0] rise_q, rise_d;
  logic [CHANNELS-1:0] phase_q, phase_d;
  logic [CHANNELS-1:0] out_n_q, out_n_d;
  logic [CNT_W-1:0]    dbcnt_q [CHANNELS];
  logic [CNT_W-1:0]    dbcnt_d [CHANNELS];
  logic [CNT_W-1:0]    pcnt_q  [CHANNELS];
  logic [CNT_W-1:0]    pcnt_d  [CHANNELS];
  logic [CNT_W-1:0]    acnt_q  [CHANNELS];
  logic [CNT_W-1:0]    acnt_d  [CHANNELS];

  always_comb begin
    logic rise_ev, auto_sel, level;
    stable_d = stable_q;
    prev_d   = prev_q;
    rise_d   = '0;
    phase_d  = phase_q;
    out_n_d  = out_n_q;
    rise_ev  = 1'b0;
    auto_sel = 1'b0;
    level    = 1'b0;
    for (int i = 0; i < CHANNELS; i++) begin
      dbcnt_d[i] = dbcnt_q[i];
      pcnt_d[i]  = pcnt_q[i];
      acnt_d[i]  = acnt_q[i];

      // Edge history holds through freeze so a pause never manufactures or loses an edge.
      rise_ev   = ~freeze & stable_q[i] & ~prev_q[i];
      rise_d[i] = rise_ev;
      if (!freeze) prev_d[i] = stable_q[i];

      if (!freeze) begin
        if (db_len == '0) begin
          stable_d[i] = s2_q[i];
          dbcnt_d[i]  = '0;
        end else if (s2_q[i] == stable_q[i]) begin
          dbcnt_d[i] = '0;
        end else if (tick) begin
          if (dbcnt_q[i] == db_len - CNT_W'(1)) begin
            stable_d[i] = s2_q[i];
            dbcnt_d[i]  = '0;
          end else begin
            dbcnt_d[i] = dbcnt_q[i] + CNT_W'(1);
          end
        end
      end

      if (!mode_pulse[i]) begin
        pcnt_d[i] = '0;
      end else if (!freeze) begin
        if (rise_ev && pcnt_q[i] == '0) pcnt_d[i] = pulse_len;
        else if (tick && pcnt_q[i] != '0) pcnt_d[i] = pcnt_q[i] - CNT_W'(1);
      end

      auto_sel = mode_auto[i] & ~mode_pulse[i] & (auto_half != '0);
      if (!auto_sel || !stable_q[i]) begin
        acnt_d[i]  = '0;
        phase_d[i] = 1'b0;
      end else if (!freeze) begin
        if (rise_ev) begin
          acnt_d[i]  = '0;
          phase_d[i] = 1'b1;
        end else if (tick) begin
          if (acnt_q[i] == auto_half - CNT_W'(1)) begin
            acnt_d[i]  = '0;
            phase_d[i] = ~phase_q[i];
          end else begin
            acnt_d[i] = acnt_q[i] + CNT_W'(1);
          end
        end
      end

      // Level uses next-state so every mode shows its first change with the rise strobe.
      if (mode_pulse[i])  level = (pcnt_d[i] != '0);
      else if (auto_sel)  level = stable_q[i] & phase_d[i];
      else                level = stable_q[i];
      if (!freeze) out_n_d[i] = ~level;
    end
  end

  always_ff @(posedge clk_sys or posedge reset) begin
    if (reset) begin
      s1_q     <= '0;
      s2_q     <= '0;
      stable_q <= '0;
      prev_q   <= '0;
      rise_q   <= '0;
      phase_q  <= '0;
      out_n_q  <= '1;
      for (int i = 0; i < CHANNELS; i++) begin
        dbcnt_q[i] <= '0;
        pcnt_q[i]  <= '0;
        acnt_q[i]  <= '0;
      end
    end else begin
      s1_q     <= raw;
      s2_q     <= s1_q;
      stable_q <= stable_d;
      prev_q   <= prev_d;
      rise_q   <= rise_d;
      phase_q  <= phase_d;
      out_n_q  <= out_n_d;
      for (int i = 0; i < CHANNELS; i++) begin
        dbcnt_q[i] <= dbcnt_d[i];
        pcnt_q[i]  <= pcnt_d[i];
        acnt_q[i]  <= acnt_d[i];
      end
    end
  end

  assign out_n = out_n_q;
  assign rise  = rise_q;

`ifdef INPUT_COND_STICKY_EN
  logic [CHANNELS-1:0] sticky_q, sticky_d;

  // Set beats clear when both land on the same cycle.
  always_comb begin
    sticky_d = rise_q | (sticky_clr ? '0 : sticky_q);
  end

  always_ff @(posedge clk_sys or posedge reset) begin
    if (reset) sticky_q <= '0;
    else       sticky_q <= sticky_d;
  end

  assign sticky = sticky_q;
`else
  logic unused_sticky_clr;
  assign unused_sticky_clr = sticky_clr;
  assign sticky = '0;
`endif

endmodule

// File: tb/tb_arcade_input_cond.sv
// Directed bench for arcade_input_cond: sync latency, debounce, pulse, autofire, freeze, sticky.
module tb_arcade_input_cond;
  localparam int unsigned CH = 16;
  localparam int unsigned CW = 8;

  logic          clk_sys = 1'b0;
  logic          reset, tick, freeze, sticky_clr;
  logic [CH-1:0] raw, mode_pulse, mode_auto;
  logic [CW-1:0] db_len, pulse_len, auto_half;
  logic [CH-1:0] out_n, rise, sticky;

  int checks = 0;
  int errors = 0;

  arcade_input_cond #(.CHANNELS(CH), .CNT_W(CW)) dut (
    .clk_sys    (clk_sys),
    .reset      (reset),
    .tick       (tick),
    .raw        (raw),
    .mode_pulse (mode_pulse),
    .mode_auto  (mode_auto),
    .db_len     (db_len),
    .pulse_len  (pulse_len),
    .auto_half  (auto_half),
    .freeze     (freeze),
    .sticky_clr (sticky_clr),
    .out_n      (out_n),
    .rise       (rise),
    .sticky     (sticky)
  );

  always #5 clk_sys = ~clk_sys;

  task automatic cyc(input int n);
    repeat (n) begin
      @(posedge clk_sys);
      #1;
    end
  endtask

  task automatic do_tick();
    tick = 1'b1;
    cyc(1);
    tick = 1'b0;
    cyc(1);
  endtask

  task automatic chk(input string tag, input logic [CH-1:0] obs, input logic [CH-1:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  logic [CH-1:0] exp_sticky;

  initial begin
    reset = 1'b1; tick = 1'b0; freeze = 1'b0; sticky_clr = 1'b0;
    raw = '0; mode_pulse = '0; mode_auto = '0;
    db_len = '0; pulse_len = '0; auto_half = '0;
    #12;
    chk("reset_out_n", out_n, 16'hffff);
    chk("reset_rise", rise, 16'h0000);
    chk("reset_sticky", sticky, 16'h0000);
    @(negedge clk_sys);
    reset = 1'b0;
    cyc(2);

    // Latency: raw[0] edge visible on the 4th edge
    raw[0] = 1'b1;
    cyc(1);
    chk("lat_e1", out_n, 16'hffff);
    cyc(2);
    chk("lat_e3", out_n, 16'hffff);
    chk("lat_e3_rise", rise, 16'h0000);
    cyc(1);
    chk("lat_e4", out_n, 16'hfffe);
    chk("lat_e4_rise", rise, 16'h0001);
    cyc(1);
    chk("lat_e5_rise", rise, 16'h0000);
    raw[0] = 1'b0;
    cyc(4);
    chk("lat_release", out_n, 16'hffff);

    // Debounce db_len=3: short burst rejected, long burst accepted on 3rd tick
    db_len = 8'd3;
    raw[2] = 1'b1;
    cyc(2);
    do_tick();
    do_tick();
    raw[2] = 1'b0;
    cyc(3);
    chk("db_burst1", out_n, 16'hffff);
    raw[2] = 1'b1;
    cyc(2);
    do_tick();
    do_tick();
    chk("db_tick2", out_n, 16'hffff);
    tick = 1'b1;
    cyc(1);
    tick = 1'b0;
    chk("db_tick3_edge", out_n, 16'hffff);
    cyc(1);
    chk("db_tick3_out", out_n, 16'hfffb);
    chk("db_tick3_rise", rise, 16'h0004);
    do_tick();
    chk("db_tick4", out_n, 16'hfffb);
    raw[2] = 1'b0;
    cyc(2);
    do_tick();
    do_tick();
    do_tick();
    chk("db_release", out_n, 16'hffff);
    db_len = '0;

    // Pulse mode on ch8, pulse_len=5, with a re-press mid-pulse
    mode_pulse[8] = 1'b1;
    pulse_len = 8'd5;
    raw[8] = 1'b1;
    cyc(4);
    chk("pls_start", out_n, 16'hfeff);
    chk("pls_rise", rise, 16'h0100);
    do_tick();
    do_tick();
    chk("pls_t2", out_n, 16'hfeff);
    raw[8] = 1'b0;
    cyc(4);
    chk("pls_release_hold", out_n, 16'hfeff);
    raw[8] = 1'b1;
    cyc(4);
    chk("pls_repress_rise", rise, 16'h0100);
    chk("pls_repress_low", out_n, 16'hfeff);
    do_tick();
    do_tick();
    chk("pls_t4", out_n, 16'hfeff);
    do_tick();
    chk("pls_t5_end", out_n, 16'hffff);
    for (int k = 0; k < 10; k++) do_tick();
    chk("pls_held_high", out_n, 16'hffff);
    chk("pls_no_rise", rise, 16'h0000);
    raw[8] = 1'b0;
    cyc(4);

    // Freeze mid-pulse at pcnt=3
    raw[8] = 1'b1;
    cyc(4);
    chk("frz_start", out_n, 16'hfeff);
    do_tick();
    do_tick();
    freeze = 1'b1;
    cyc(1);
    for (int k = 0; k < 10; k++) do_tick();
    chk("frz_held", out_n, 16'hfeff);
    chk("frz_rise", rise, 16'h0000);
    freeze = 1'b0;
    cyc(1);
    chk("frz_resume", out_n, 16'hfeff);
    chk("frz_resume_rise", rise, 16'h0000);
    do_tick();
    do_tick();
    chk("frz_t2", out_n, 16'hfeff);
    do_tick();
    chk("frz_t3_end", out_n, 16'hffff);
    raw[8] = 1'b0;
    cyc(4);
    mode_pulse[8] = 1'b0;
    cyc(1);
    chk("frz_done", out_n, 16'hffff);

    // Autofire ch4, half-period 2 ticks
    mode_auto[4] = 1'b1;
    auto_half = 8'd2;
    raw[4] = 1'b1;
    cyc(4);
    chk("auto_k0", out_n, 16'hffef);
    for (int k = 1; k <= 9; k++) begin
      do_tick();
      chk($sformatf("auto_k%0d", k), out_n, (((k / 2) % 2) == 0) ? 16'hffef : 16'hffff);
    end
    raw[4] = 1'b0;
    cyc(3);
    chk("auto_rel_e3", out_n, 16'hffef);
    cyc(1);
    chk("auto_rel_e4", out_n, 16'hffff);
    auto_half = '0;
    raw[4] = 1'b1;
    cyc(4);
    for (int k = 0; k < 5; k++) do_tick();
    chk("auto_off_level", out_n, 16'hffef);
    raw[4] = 1'b0;
    cyc(4);
    chk("auto_off_rel", out_n, 16'hffff);
    mode_auto[4] = 1'b0;

    // Sticky: set wins over clear, clear alone empties
    raw[1] = 1'b1;
    cyc(4);
    chk("stk_rise", rise, 16'h0002);
    sticky_clr = 1'b1;
    cyc(1);
`ifdef INPUT_COND_STICKY_EN
    exp_sticky = 16'h0002;
`else
    exp_sticky = 16'h0000;
`endif
    chk("stk_set_wins", sticky, exp_sticky);
    cyc(1);
    chk("stk_cleared", sticky, 16'h0000);
    sticky_clr = 1'b0;
    raw[1] = 1'b0;
    cyc(4);
    chk("stk_ch1_rel", out_n, 16'hffff);

    // Reset mid-pulse returns out_n high asynchronously
    mode_pulse[8] = 1'b1;
    pulse_len = 8'd5;
    raw[8] = 1'b1;
    cyc(4);
    chk("rst_pulse_low", out_n, 16'hfeff);
    #2;
    reset = 1'b1;
    #1;
    chk("rst_async", out_n, 16'hffff);
    chk("rst_async_sticky", sticky, 16'h0000);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
